nibble_serial_cla_adder: RTL and testbench
==========================================

Name: nibble_serial_cla_adder

Overview:
- Multi-cycle adder/subtractor for operands of 4*NIBBLES bits, processed one 4-bit nibble per clock.
- Per nibble it generates P = A^B and G = A&B and applies the 4-bit carry-lookahead equations internally to get C[4:1]. It forms sum = P ^ {C[3:1], Cin} and registers C[4] as the next nibble's Cin.
- Sits on the producer side of the P/G/Cin -> C lookahead interface.
- Valid/ready handshakes on input and output, for datapaths that trade area for latency.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles; operand width W = 4*NIBBLES; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add mode.
- sub  input  1  1 = A-B (subtract mode).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry out of MSB (subtract mode: 1 = no borrow).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, nibble index=0, carry reg=0. Reset mid-operation aborts the calculation with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture: a into A_reg; b into B_reg (subtract mode: b inverted); carry reg = subtract mode ? 1 : cin.
  - Clear sum register; idx=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, take nibble idx of A_reg/B_reg: P=A^B, G=A&B.
  - C1=G0|P0Ci
  - C2=G1|P1G0|P1P0Ci
  - C3=G2|P2G1|P2P1G0|P2P1P0Ci
  - C4=G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0Ci
  - Write sum[4*idx+3:4*idx] = P ^ {C3,C2,C1,Ci}; carry reg <= C4.
  - If idx==NIBBLES-1: cout<=C4, ovf<=C3^C4, go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1.
  - sum/cout/ovf held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
- Latency:
  - Accept edge to out_valid high is NIBBLES+1 clocks.
  - Throughput is one operation per NIBBLES+2 clocks minimum; in_ready is not asserted in DONE.
- Inputs a/b/cin/sub are sampled only at the accept edge; later changes have no effect.
- in_valid while busy is ignored (no capture); the producer must hold until in_ready.
- NIBBLES=1: a single CALC cycle.
- idx counter width is clog2(NIBBLES), minimum 1 bit; it never wraps past NIBBLES-1.

Optional Feature:
- Macro: NIBSER_SUB_EN.
- Defined: sub port honoured as described (B inverted, initial carry=1, cin ignored).
- Undefined: sub port is ignored; always A+B+cin; no inversion logic synthesized.

Test Plan:
- Add, NIBBLES=4: a=0x1234, b=0x4321, cin=0, sub=0 -> after 5 clocks out_valid=1, sum=0x5555, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Separately, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract (NIBSER_SUB_EN defined): a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. With the macro undefined, same stimulus -> sum=0x000C.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> sum/cout/ovf stable; in_ready=0 throughout.
  - Pulse in_valid with new operands during CALC -> no capture, first result unaffected.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: accept a=0x1111, b=0x2222, drop rst_n during idx=2 -> immediately out_valid=0, in_ready=1, sum=0. Next op a=0x0001, b=0x0001 -> sum=0x0002.

Source files
------------

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle adder/subtractor: one 4-bit carry-lookahead nibble per clock, valid/ready on both sides.
// Optional subtract mode is compiled in with `define NIBSER_SUB_EN.
module nibble_serial_cla_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [W-1:0]     w_b_in;
  logic             w_c0;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:0]       w_c;
  logic [3:0]       w_nib_sum;
  logic             w_last;

`ifdef NIBSER_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c0   = sub ? 1'b1 : cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_in       = b;
  assign w_c0         = cin;
`endif

  assign w_last = (r_idx == LAST_IDX);

  // Lookahead over the current nibble; w_c[0] is the carry entering it.
  always_comb begin
    w_a_nib   = r_a[4*r_idx +: 4];
    w_b_nib   = r_b[4*r_idx +: 4];
    w_p       = w_a_nib ^ w_b_nib;
    w_g       = w_a_nib & w_b_nib;
    w_c[0]    = r_carry;
    w_c[1]    = w_g[0] | (w_p[0] & r_carry);
    w_c[2]    = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3]    = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c[4]    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_nib_sum = w_p ^ w_c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_CALC;
      S_CALC:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c0;
            r_sum   <= '0;
            r_idx   <= '0;
          end
        end
        S_CALC: begin
          r_sum[4*r_idx +: 4] <= w_nib_sum;
          r_carry             <= w_c[4];
          if (w_last) begin
            r_cout <= w_c[4];
            r_ovf  <= w_c[3] ^ w_c[4];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Directed bench for nibble_serial_cla_adder (NIBBLES=4) with immediate-assertion checks.
module tb_nibble_serial_cla_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_cla_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble inputs afterwards, check latency and result, then drain it.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    check({tag, "_rdy_before"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    for (int k = 1; k < N; k++) tick();
    check({tag, "_vld_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"},  {16'd0, sum}, {16'd0, esum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    check({tag, "_ovf"},  {31'd0, ovf}, {31'd0, eovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum}, 32'd0);
    check("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("cin",     16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
`ifdef NIBSER_SUB_EN
    run_op("sub",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_nb",  16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0);
`else
    run_op("sub",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
    run_op("sub_nb",  16'h0009, 16'h0003, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif

    // Backpressure with an ignored in_valid pulse during CALC
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    check("bp_busy_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_vld_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("bp_vld", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_sum", {16'd0, sum}, 32'h1010);
      check("bp_hold_flags", {28'd0, in_ready, out_valid, cout, ovf}, 32'h4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'h2);
    tick();
    check("bp_no_second", {30'd0, in_ready, out_valid}, 32'h2);

    // Reset in the middle of CALC at idx=2
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_partial", {16'd0, sum}, 32'h0033);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_no_output", {31'd0, out_valid}, 32'd0);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
